// File: rtl/ex_div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The execute stage is the master; the divider is the slave.
interface ex_div_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        abort_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, abort_i,
        input  busy_o, ready_o, result_o, rd_addr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, abort_i,
        output busy_o, ready_o, result_o, rd_addr_o
    );
endinterface

// File: rtl/ex_div.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring radix-2 divider, one quotient bit per
// cycle. busy_o is the execute-stage stall request, ready_o a one-cycle result strobe.
module ex_div (
    input  logic    clk,
    input  logic    rst_n,
    ex_div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [4:0]  count_r;
    logic [31:0] dvsr_r;      // divisor magnitude
    logic [31:0] quo_r;       // dividend bits shifting out, quotient bits shifting in
    logic [32:0] rem_r;       // partial remainder
    logic        is_rem_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        ready_r;
    logic [31:0] result_r;
    logic [4:0]  rd_r;

    logic        signed_op_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div0_s;
    logic        ovf_s;
    logic [31:0] special_s;
    logic [32:0] shifted_s;
    logic [33:0] diff_s;
    logic        q_bit_s;
    logic [32:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] final_s;
    logic        busy_s;

    // Operand magnitudes and special-case detection from the live request.
    always_comb begin
        signed_op_s = ~bus.op_i[0];
        if (signed_op_s && bus.dividend_i[31]) begin
            a_mag_s = 32'd0 - bus.dividend_i;
        end else begin
            a_mag_s = bus.dividend_i;
        end
        if (signed_op_s && bus.divisor_i[31]) begin
            b_mag_s = 32'd0 - bus.divisor_i;
        end else begin
            b_mag_s = bus.divisor_i;
        end
        div0_s = (bus.divisor_i == 32'd0);
        ovf_s  = signed_op_s && (bus.dividend_i == 32'h8000_0000) &&
                 (bus.divisor_i == 32'hFFFF_FFFF);
        if (div0_s) begin
            special_s = bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF;
        end else begin
            special_s = bus.op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step plus final sign fix-up of quotient or remainder.
    always_comb begin
        shifted_s = {rem_r[31:0], quo_r[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvsr_r};
        q_bit_s   = ~diff_s[33];
        if (q_bit_s) begin
            rem_next_s = diff_s[32:0];
        end else begin
            rem_next_s = shifted_s;
        end
        quo_next_s = {quo_r[30:0], q_bit_s};
        if (is_rem_r) begin
            final_s = r_neg_r ? (32'd0 - rem_next_s[31:0]) : rem_next_s[31:0];
        end else begin
            final_s = q_neg_r ? (32'd0 - quo_next_s) : quo_next_s;
        end
    end

    // Stall request: raised in the request cycle itself, dropped in DONE and on abort.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = bus.start_i & ~bus.abort_i;
            CALC:    busy_s = ~bus.abort_i;
            DONE:    busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    assign bus.busy_o    = busy_s & rst_n;
    assign bus.ready_o   = ready_r & ~bus.abort_i;
    assign bus.result_o  = result_r;
    assign bus.rd_addr_o = rd_r;

    // Control FSM and datapath registers; abort returns to IDLE from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            count_r  <= 5'd0;
            dvsr_r   <= 32'd0;
            quo_r    <= 32'd0;
            rem_r    <= 33'd0;
            is_rem_r <= 1'b0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= 32'd0;
            rd_r     <= 5'd0;
        end else if (bus.abort_i) begin
            state_r <= IDLE;
            count_r <= 5'd0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.start_i) begin
                        rd_r     <= bus.rd_addr_i;
                        is_rem_r <= bus.op_i[1];
                        q_neg_r  <= signed_op_s & (bus.dividend_i[31] ^ bus.divisor_i[31]);
                        r_neg_r  <= signed_op_s & bus.dividend_i[31];
                        quo_r    <= a_mag_s;
                        dvsr_r   <= b_mag_s;
                        rem_r    <= 33'd0;
                        count_r  <= 5'd0;
                        if (div0_s || ovf_s) begin
                            state_r  <= DONE;
                            ready_r  <= 1'b1;
                            result_r <= special_s;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        state_r  <= DONE;
                        ready_r  <= 1'b1;
                        result_r <= final_s;
                    end
                end
                DONE: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever ready_o is seen.
module tb_ex_div;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    ex_div_if bus ();

    ex_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready_o strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ready at cycle %0d result=%h", cyc, bus.result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total += 3;
                if (bus.result_o !== e.res) begin
                    bad++;
                    $display("FAIL result got=%h exp=%h", bus.result_o, e.res);
                end
                if (bus.rd_addr_o !== e.rd) begin
                    bad++;
                    $display("FAIL rd_addr got=%0d exp=%0d", bus.rd_addr_o, e.rd);
                end
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL ready_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing ready, %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue one op, check the busy window, hold start through DONE, then release.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        int   busy_err;
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.rd_addr_i  = rd;
        e.res = exp;
        e.rd  = rd;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        busy_err = 0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (bus.busy_o !== ((k < lat) ? 1'b1 : 1'b0)) busy_err++;
        end
        total++;
        if (busy_err != 0) begin
            bad++;
            $display("FAIL %s busy_window wrong_cycles=%0d required=0", name, busy_err);
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        check_drained(name);
    endtask

    initial begin
        int busy_err;
        cyc            = 0;
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        bus.rd_addr_i  = 5'd0;
        bus.abort_i    = 1'b0;

        #12;
        check("reset_busy",   {31'd0, bus.busy_o},  32'd0);
        check("reset_ready",  {31'd0, bus.ready_o}, 32'd0);
        check("reset_result", bus.result_o,         32'd0);
        check("reset_rd",     {27'd0, bus.rd_addr_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op("divu_100_7",   2'b01, 32'd100,         32'd7,          5'd5,  32'd14,          33);
        do_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,   32'd2,          5'd6,  32'hFFFF_FFFD,   33);
        do_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,   32'd2,          5'd7,  32'hFFFF_FFFF,   33);
        do_op("remu_big_2",   2'b11, 32'hFFFF_FFF9,   32'd2,          5'd8,  32'd1,           33);
        do_op("div_7_m2",     2'b00, 32'd7,           32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,   33);
        do_op("rem_7_m2",     2'b10, 32'd7,           32'hFFFF_FFFE,  5'd10, 32'd1,           33);
        do_op("divu_min_m1",  2'b01, 32'h8000_0000,   32'hFFFF_FFFF,  5'd11, 32'd0,           33);
        do_op("div_by0",      2'b00, 32'd1234,        32'd0,          5'd12, 32'hFFFF_FFFF,   1);
        do_op("rem_by0",      2'b10, 32'd1234,        32'd0,          5'd13, 32'd1234,        1);
        do_op("divu_by0",     2'b01, 32'd77,          32'd0,          5'd14, 32'hFFFF_FFFF,   1);
        do_op("remu_by0",     2'b11, 32'd5,           32'd0,          5'd15, 32'd5,           1);
        do_op("div_ovf",      2'b00, 32'h8000_0000,   32'hFFFF_FFFF,  5'd16, 32'h8000_0000,   1);
        do_op("rem_ovf",      2'b10, 32'h8000_0000,   32'hFFFF_FFFF,  5'd17, 32'd0,           1);

        // Abort at CALC cycle N+10: busy drops at once and no strobe follows.
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b01;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        bus.rd_addr_i  = 5'd20;
        repeat (10) @(posedge clk);
        #1;
        bus.abort_i = 1'b1;
        bus.start_i = 1'b0;
        #1;
        check("abort_busy_same_cycle", {31'd0, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.abort_i = 1'b0;
        busy_err = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b0) busy_err++;
        end
        check("abort_busy_after", busy_err, 32'd0);
        do_op("divu_9_3_after_abort", 2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 33);

        // Start and abort together in IDLE: nothing starts.
        @(posedge clk);
        #1;
        bus.start_i     = 1'b1;
        bus.abort_i     = 1'b1;
        bus.dividend_i  = 32'd50;
        bus.divisor_i   = 32'd5;
        #1;
        check("start_abort_busy", {31'd0, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        busy_err = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b0) busy_err++;
        end
        check("start_abort_idle", busy_err, 32'd0);

        // Reset pulled mid-CALC: outputs clear immediately, no strobe afterwards.
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b01;
        bus.dividend_i = 32'd12345;
        bus.divisor_i  = 32'd11;
        bus.rd_addr_i  = 5'd22;
        repeat (12) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("midreset_busy",   {31'd0, bus.busy_o},    32'd0);
        check("midreset_ready",  {31'd0, bus.ready_o},   32'd0);
        check("midreset_result", bus.result_o,           32'd0);
        check("midreset_rd",     {27'd0, bus.rd_addr_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_drained("post_reset_quiet");
        do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, instantiated beside the execute stage. It produces the execute stage's multi-clock wait request to the pipeline controller: while it computes, `busy_o` holds PC, IF/ID and ID/EX in place. Its one-cycle result strobe lets execute release the stall and forward the quotient or remainder to writeback. Single clock domain; restoring radix-2 algorithm, one quotient bit per cycle.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  execute has a divide op and wants it done; level, held while the op sits in EX.
- `op_i`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i`  in  32  rs1 value.
- `divisor_i`  in  32  rs2 value.
- `rd_addr_i`  in  5  destination register.
- `abort_i`  in  1  cancel any operation (interrupt/halt flush).
- `busy_o`  out  1  stall request; wired as the EX multi-clock wait request.
- `ready_o`  out  1  one-cycle result-valid strobe.
- `result_o`  out  32  quotient or remainder per latched op.
- `rd_addr_o`  out  5  latched destination register.

## Operation
- States: IDLE, CALC, DONE.
- Operands, op and rd are latched on the edge that leaves IDLE.
- IDLE:
  - `start_i`=1 and `abort_i`=0 latch operands.
  - Divisor 0: go to DONE.
  - DIV/REM with dividend 0x8000_0000 and divisor 0xFFFF_FFFF (overflow): go to DONE.
  - Otherwise: go to CALC with count=0.
- CALC:
  - Datapath works on magnitudes: |dividend| and |divisor| for DIV/REM, raw values for DIVU/REMU.
  - Partial remainder is 33 bits. Each cycle: shift in the next dividend bit, MSB first.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit 1; else restore and set 0.
  - Increment count. After count=31 is processed, go to DONE.
- DONE:
  - Assert `ready_o` for one cycle and drive `result_o`, then go to IDLE.
  - `start_i` is ignored in DONE, so the still-present op does not restart.
- Result rules:
  - Normal DIV: quotient negated iff operand signs differ.
  - Normal REM: remainder takes the dividend's sign.
  - Divide by zero: quotient 0xFFFF_FFFF (DIV and DIVU); remainder = dividend.
  - Overflow: quotient 0x8000_0000, remainder 0.
- `busy_o` is combinational:
  - IDLE: `start_i & ~abort_i`. This stalls the pipeline in the request cycle itself.
  - CALC: 1.
  - DONE: 0. This releases the pipeline the same cycle the result is valid.
- `abort_i` has priority over everything. From any state it goes to IDLE on the next edge, with no `ready_o` and `busy_o`=0 in that cycle.
- `result_o` and `rd_addr_o` are meaningful only while `ready_o`=1. They hold their last value otherwise.

## Timing
- Reset (async, `rst_n`=0):
  - state goes to IDLE, count to 0, internal registers to 0.
  - `ready_o`=0, `result_o`=0, `rd_addr_o`=0.
  - `busy_o` is forced to 0 while `rst_n`=0.
- Reset mid-CALC discards the operation. No strobe is issued after reset release.
- Normal op, with `start_i` first high in cycle N:
  - CALC occupies cycles N+1..N+32.
  - DONE is cycle N+33.
  - `busy_o` is high N..N+32.
  - `ready_o` is high in N+33 only.
- Special case (div-by-zero, overflow): `busy_o` high in N only; `ready_o` high in N+1.
- Back-to-back divides: a new `start_i` is accepted in the first IDLE cycle after DONE, i.e. N+34 at the earliest.
- Abort and start together in IDLE: no operation starts, `busy_o`=0.

## Test plan
- DIVU 100/7, rd=5, start in cycle N:
  - `busy_o` high N..N+32.
  - `ready_o` pulse in N+33 with `result_o`=14 and `rd_addr_o`=5.
  - `start_i` still high in N+33 does not retrigger.
- DIV −7/2 gives 0xFFFF_FFFD (−3). REM −7/2 gives 0xFFFF_FFFF (−1). REMU 0xFFFF_FFF9/2 gives 1. Each reports `ready_o` at N+33.
- Divide by zero:
  - DIV 1234/0: `ready_o` at N+1 with 0xFFFF_FFFF.
  - REM 1234/0: 1234.
  - `busy_o` high only in cycle N.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF gives 0x8000_0000 and REM gives 0. Both have `ready_o` at N+1.
- Abort asserted at CALC cycle N+10:
  - `busy_o`=0 from N+11.
  - No `ready_o` ever.
  - A subsequent DIVU 9/3 returns 3 with normal latency.
- `rst_n` pulled low mid-CALC:
  - All outputs read 0 immediately.
  - After release, no spurious `ready_o`.
  - Fresh DIVU 0xFFFF_FFFF/1 returns 0xFFFF_FFFF.
